fractal_sync_rx: RTL
====================

Name: fractal_sync_rx

Overview:
- Receive-side datapath of a fractal synchronization node, the counterpart of the node's response transmitter.
- Accepts synchronization requests from two child channels: channel 0 (east/north) and channel 1 (west/south).
- Each channel samples its request and buffers it in a dedicated FIFO.
- A round-robin arbiter merges both FIFOs into one valid/ready stream toward the node control / register-file check logic.
- Per-channel overflow errors are reported as a pulse and as a sticky flag.

Parameters:
- fsync_req_t, logic: request type; must contain 1-bit field sync (request valid), remaining fields are opaque payload.
- COMB_IN, 1'b0: 1 = requests pushed combinationally from inputs; 0 = inputs registered first.
- FIFO_DEPTH, 2: entries per channel FIFO; must be > 0, fatal assertion otherwise.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ch0_req_i  in  fsync_req_t  channel 0 request; pushed when .sync=1.
- ch1_req_i  in  fsync_req_t  channel 1 request; pushed when .sync=1.
- req_o  out  fsync_req_t  head of the granted channel FIFO.
- ch_o  out  1  channel index of req_o.
- valid_o  out  1  req_o/ch_o valid.
- ready_i  in  1  consumer accepts; transfer = valid_o & ready_i.
- ch0_error_overflow_o  out  1  pulse: channel 0 push dropped.
- ch1_error_overflow_o  out  1  pulse: channel 1 push dropped.
- error_sticky_o  out  2  bit c set on channel c overflow.
- clr_error_i  in  1  clears error_sticky_o.
- ch0_empty_o  out  1  channel 0 FIFO empty.
- ch1_empty_o  out  1  channel 1 FIFO empty.

Behaviour:
Reset:
- Async on rst_ni low.
- FIFOs empty, sampled requests '0, sticky '0, RR pointer = channel 0.
- Outputs: valid_o=0, req_o='0, ch_o=0, error pulses 0, empties 1.

Sampling:
- COMB_IN=0: per channel, push_c is registered from .sync; the sample register loads only when .sync=1.
- COMB_IN=1: push_c = .sync, data taken directly from the input.

FIFO:
- Circular buffer with read/write pointers and occupancy counter 0..FIFO_DEPTH.
- Pointers wrap FIFO_DEPTH-1 -> 0; non-power-of-2 depths supported.
- Head is read from storage (registered, not fall-through).

Latency (input .sync high in cycle 0, consumer idle):
- COMB_IN=1: valid_o=1 in cycle 1.
- COMB_IN=0: valid_o=1 in cycle 2.

Arbitration:
- Only non-empty channels are eligible.
- Both eligible: grant the RR pointer channel.
- One eligible: grant it, regardless of pointer.
- ch_o = granted channel.
- On transfer, the granted channel pops and the pointer moves to the other channel. The pointer is unchanged without a transfer.
- valid_o/req_o/ch_o are stable while valid_o & ~ready_i; no grant switch while stalled.

Boundary conditions:
- Full, push, no pop: request dropped, FIFO unchanged, error pulse high that cycle, sticky bit set next edge.
- Full, push and pop same cycle: push accepted, count unchanged, no error.
- Empty, push and pop on the same channel: impossible, since a channel is only popped when non-empty.
- clr_error_i and a new overflow in the same cycle: sticky bit ends set (set wins).
- Reset mid-operation: all buffered requests are discarded; behaviour returns to the reset state.

Test Plan:
- COMB_IN=0, DEPTH=2, ready_i=1; ch0 .sync=1 payload 0xA5 in cycle 0 -> cycle 2: valid_o=1, req_o payload 0xA5, ch_o=0; cycle 3 valid_o=0.
- Both FIFOs hold 2 entries (ch0: A,B; ch1: C,D), ready_i=1 -> output order A(0), C(1), B(0), D(1); ch0_empty_o and ch1_empty_o =1 afterward.
- ready_i=0, ch0 filled with E,F, third ch0 push G -> ch0_error_overflow_o pulses for one cycle, error_sticky_o=2'b01; after ready_i=1 outputs E,F only.
- ch0 full, ready_i=1 holding ch0 granted, new ch0 push same cycle -> no error; count stays 2.
- error_sticky_o=2'b01, clr_error_i=1 alone -> 2'b00 next cycle. clr_error_i together with a ch1 overflow -> 2'b10.
- Two entries buffered, rst_ni pulsed low mid-cycle -> valid_o=0 immediately, empties=1, RR pointer=0; the first post-reset request is delivered normally.

Source files
------------

// File: rtl/fractal_sync_rx.sv
// Receive datapath of a fractal synchronization node: samples requests from two
// child channels, buffers each in its own FIFO and merges them round-robin into
// one valid/ready stream, flagging per-channel overflow as pulse and sticky bit.

package fractal_sync_rx_pkg;

  localparam int unsigned PayloadW = 8;

  typedef struct packed {
    logic [PayloadW-1:0] payload;
    logic                sync;
  } fsync_req_t;

endpackage

module fractal_sync_rx #(
  parameter type         fsync_req_t = fractal_sync_rx_pkg::fsync_req_t,
  parameter logic        COMB_IN     = 1'b0,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  fsync_req_t ch0_req_i,
  input  fsync_req_t ch1_req_i,
  output fsync_req_t req_o,
  output logic       ch_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       ch0_error_overflow_o,
  output logic       ch1_error_overflow_o,
  output logic [1:0] error_sticky_o,
  input  logic       clr_error_i,
  output logic       ch0_empty_o,
  output logic       ch1_empty_o
);

  localparam int unsigned NumCh = 2;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH == 0) begin : g_depth_check
    $fatal(1, "fractal_sync_rx: FIFO_DEPTH must be greater than 0");
  end

  // Wrap-around pointer increment, valid for any depth (not only powers of 2)
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  fsync_req_t       in_req    [NumCh];
  fsync_req_t       push_data [NumCh];
  logic [NumCh-1:0] push;

  fsync_req_t       mem_q  [NumCh][FIFO_DEPTH];
  logic [PtrW-1:0]  wptr_q [NumCh];
  logic [PtrW-1:0]  rptr_q [NumCh];
  logic [CntW-1:0]  cnt_q  [NumCh];

  logic [NumCh-1:0] empty, full, pop, wr_en, ovf;
  logic [NumCh-1:0] sticky_q;
  logic             rr_q, lock_q, lock_ch_q;
  logic             gnt, valid, xfer;

  // Channel inputs gathered into an array for uniform per-channel handling
  always_comb begin
    in_req[0] = ch0_req_i;
    in_req[1] = ch1_req_i;
  end

  if (COMB_IN) begin : g_comb_in
    // Requests go straight from the inputs into the FIFOs
    always_comb begin
      for (int c = 0; c < NumCh; c++) begin
        push[c]      = in_req[c].sync;
        push_data[c] = in_req[c];
      end
    end
  end else begin : g_reg_in
    logic [NumCh-1:0] smp_push_q;
    fsync_req_t       smp_q [NumCh];

    // Input sample stage; payload register only loads on a valid request
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        smp_push_q <= '0;
        for (int c = 0; c < NumCh; c++) smp_q[c] <= '0;
      end else begin
        for (int c = 0; c < NumCh; c++) begin
          smp_push_q[c] <= in_req[c].sync;
          if (in_req[c].sync) smp_q[c] <= in_req[c];
        end
      end
    end

    // Registered samples feed the FIFOs
    always_comb begin
      for (int c = 0; c < NumCh; c++) begin
        push[c]      = smp_push_q[c];
        push_data[c] = smp_q[c];
      end
    end
  end

  // FIFO occupancy status
  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      empty[c] = (cnt_q[c] == '0);
      full[c]  = (cnt_q[c] == CntW'(FIFO_DEPTH));
    end
  end

  // Round-robin grant, held on the stalled channel until the transfer completes
  always_comb begin
    valid = |(~empty);
    gnt   = 1'b0;
    if (lock_q) begin
      gnt = lock_ch_q;
    end else if (!empty[0] && !empty[1]) begin
      gnt = rr_q;
    end else if (!empty[1]) begin
      gnt = 1'b1;
    end
    xfer  = valid & ready_i;
    pop   = {xfer & gnt, xfer & ~gnt};
    wr_en = '0;
    ovf   = '0;
    for (int c = 0; c < NumCh; c++) begin
      wr_en[c] = push[c] & (~full[c] | pop[c]);
      ovf[c]   = push[c] & full[c] & ~pop[c];
    end
  end

  // FIFO pointers and occupancy counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCh; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        if (wr_en[c]) wptr_q[c] <= ptr_inc(wptr_q[c]);
        if (pop[c])   rptr_q[c] <= ptr_inc(rptr_q[c]);
        if (wr_en[c] && !pop[c]) begin
          cnt_q[c] <= cnt_q[c] + CntW'(1);
        end else if (pop[c] && !wr_en[c]) begin
          cnt_q[c] <= cnt_q[c] - CntW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while the counter says empty
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumCh; c++) begin
      if (wr_en[c]) mem_q[c][wptr_q[c]] <= push_data[c];
    end
  end

  // Arbiter pointer, stall lock and sticky error flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_ch_q <= 1'b0;
      sticky_q  <= '0;
    end else begin
      if (xfer) rr_q <= ~gnt;
      lock_q    <= valid & ~ready_i;
      lock_ch_q <= gnt;
      sticky_q  <= (sticky_q & ~{NumCh{clr_error_i}}) | ovf;
    end
  end

  assign req_o                = valid ? mem_q[gnt][rptr_q[gnt]] : '0;
  assign ch_o                 = valid & gnt;
  assign valid_o              = valid;
  assign ch0_error_overflow_o = ovf[0];
  assign ch1_error_overflow_o = ovf[1];
  assign error_sticky_o       = sticky_q;
  assign ch0_empty_o          = empty[0];
  assign ch1_empty_o          = empty[1];

endmodule
